controlador_param: RTL and testbench
====================================

CONTROLADOR_PARAM -- requirements
Module: controlador_param

Interface
REQ-001 PIN_W, 8, width of the PIN bus in bits (>=4).
REQ-002 PIN_OK, 8'h35, correct PIN value; PIN_W bits wide.
REQ-003 MAX_INTENTOS, 3, wrong PIN entries that raise Alarma (1..15).
REQ-004 T_ESPERA, 16, idle cycles in ESPERA_PIN before timeout (>=2).
REQ-005 Clk  in  1  single clock; all state changes on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Pin  in  PIN_W  PIN value, sampled only when enterPin=1.
REQ-008 enterPin  in  1  one-cycle PIN-entry strobe.
REQ-009 Vehiculo  in  1  vehicle present at the gate entry sensor.
REQ-010 Termino  in  1  vehicle has fully passed the gate.
REQ-011 Cerrado  out  1  gate closed.
REQ-012 Abierto  out  1  gate open.
REQ-013 Alarma  out  1  wrong-PIN or tailgating alarm.
REQ-014 Bloqueo  out  1  gate locked after tailgating.
REQ-015 Intentos  out  $clog2(MAX_INTENTOS+1)  current wrong-PIN count.
REQ-016 Timeout  out  1  one-cycle pulse when PIN wait expires.

Function
REQ-017 All outputs SHALL be registered (Moore); every response appears the cycle after the causing input edge.
REQ-018 States SHALL be IDLE, ESPERA_PIN, ABIERTO, BLOQUEO; Cerrado=1 in every state except ABIERTO, where Abierto=1; Abierto and Cerrado are never both 1.
REQ-019 IDLE: Vehiculo=1 -> ESPERA_PIN with Intentos=0 and the wait timer cleared.
REQ-020 ESPERA_PIN: enterPin=1 and Pin==PIN_OK -> ABIERTO, Intentos=0, Alarma=0.
REQ-021 ESPERA_PIN: enterPin=1 and Pin!=PIN_OK -> Intentos+1, saturating at MAX_INTENTOS; Alarma=1 once Intentos reaches MAX_INTENTOS; state unchanged.
REQ-022 ESPERA_PIN: wait timer clears on every enterPin and increments otherwise; on reaching T_ESPERA with Alarma=0 -> IDLE, Timeout=1 for one cycle, Intentos=0.
REQ-023 With Alarma=1 the timeout SHALL NOT fire; only a correct PIN leaves ESPERA_PIN.
REQ-024 enterPin in the same cycle the timer expires: the PIN entry wins and no Timeout pulse occurs.
REQ-025 ABIERTO: Termino=1 and Vehiculo=0 -> IDLE; Termino=1 and Vehiculo=1 -> BLOQUEO (tailgating); enterPin ignored.
REQ-026 BLOQUEO: Bloqueo=1, Alarma=1; only enterPin with Pin==PIN_OK -> IDLE (Bloqueo=0, Alarma=0, Intentos=0); wrong PINs are ignored and not counted.
REQ-027 enterPin in IDLE SHALL be ignored.
REQ-028 PIN comparison SHALL be full-width equality on PIN_W bits.

Reset
REQ-029 Reset=1 at a clock edge SHALL force IDLE, Cerrado=1, Abierto=0, Alarma=0, Bloqueo=0, Intentos=0, Timeout=0, and clear the timer, from any state including mid-entry.
REQ-030 Reset SHALL take priority over all other inputs in the same cycle.

Structure
REQ-031 State encoding (2-bit localparams IDLE=0, ESPERA_PIN=1, ABIERTO=2, BLOQUEO=3) SHALL live in a shared package/include, controlador_pkg.
REQ-032 The wait timer SHALL be a sub-module contador_espera (parameter T_ESPERA; inputs Clk, Reset, clr, en; output expired).

Verification
REQ-033 Vehiculo=1, then enterPin with Pin=8'h35 -> Abierto=1, Cerrado=0 next cycle; Termino=1, Vehiculo=0 -> Cerrado=1.
REQ-034 Three enterPin with Pin=8'h00 -> Intentos 1,2,3; Alarma=1 after third; then Pin=8'h35 -> Abierto=1, Alarma=0, Intentos=0.
REQ-035 Vehiculo=1, no enterPin for 16 cycles -> Timeout pulse for one cycle, state IDLE; repeat with Alarma=1 -> no Timeout.
REQ-036 In ABIERTO, Termino=1 with Vehiculo=1 -> Bloqueo=1, Alarma=1; Pin=8'h11 ignored; Pin=8'h35 -> IDLE, all flags 0.
REQ-037 Reset=1 during ESPERA_PIN with Intentos=2 -> next cycle Intentos=0, Cerrado=1, all other outputs 0.
REQ-038 Rerun REQ-033/034 with PIN_W=12, PIN_OK=12'hA5C, MAX_INTENTOS=5 -> Alarma only after fifth wrong entry.

Source files
------------

// File: rtl/controlador_pkg.sv
// Gate controller shared types: FSM state encoding and registered output bundle.
// Used by controlador_param and its testbench-facing top.
package controlador_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ESPERA_PIN = 2'd1,
    ABIERTO    = 2'd2,
    BLOQUEO    = 2'd3
  } estado_t;

  typedef struct packed {
    logic cerrado;
    logic abierto;
    logic alarma;
    logic bloqueo;
    logic timeout;
  } salidas_t;

  // Moore decode of the flag outputs for the state being entered.
  function automatic salidas_t flags(
    input estado_t s,
    input logic    al_pin,
    input logic    to
  );
    salidas_t o;
    o.cerrado = (s != ABIERTO);
    o.abierto = (s == ABIERTO);
    o.bloqueo = (s == BLOQUEO);
    o.alarma  = (s == BLOQUEO) ||
                ((s == ESPERA_PIN) && al_pin);
    o.timeout = to;
    return o;
  endfunction

endpackage

// File: rtl/contador_espera.sv
// PIN wait timer: counts enabled cycles, flags the cycle that reaches T_ESPERA.
// Saturates so a held alarm cannot wrap it into a spurious expiry.
module contador_espera #(
  parameter int T_ESPERA = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(T_ESPERA + 1);
  localparam logic [CW-1:0] LAST = CW'(T_ESPERA - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/controlador_param.sv
// Parameterised PIN-gate controller with wrong-PIN alarm, wait timeout
// and tailgating lock. All outputs are registered.
module controlador_param
  import controlador_pkg::*;
#(
  parameter int               PIN_W        = 8,
  parameter logic [PIN_W-1:0] PIN_OK       = 8'h35,
  parameter int               MAX_INTENTOS = 3,
  parameter int               T_ESPERA     = 16
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic [PIN_W-1:0]                    Pin,
  input  logic                                enterPin,
  input  logic                                Vehiculo,
  input  logic                                Termino,
  output logic                                Cerrado,
  output logic                                Abierto,
  output logic                                Alarma,
  output logic                                Bloqueo,
  output logic [$clog2(MAX_INTENTOS+1)-1:0]   Intentos,
  output logic                                Timeout
);

  localparam int IW = $clog2(MAX_INTENTOS + 1);
  localparam logic [IW-1:0] MAX_I = IW'(MAX_INTENTOS);

  estado_t       state;
  estado_t       nxt;
  logic [IW-1:0] intentos;
  logic [IW-1:0] nx_int;
  logic          nx_to;
  salidas_t      sal;
  salidas_t      nx_sal;
  logic          pin_ok;
  logic          clr;
  logic          en;
  logic          expired;
  logic          en_alarma;

  assign pin_ok    = (Pin == PIN_OK);
  assign en_alarma = (intentos == MAX_I);

  // Timer only runs while waiting; any PIN entry restarts it.
  assign clr = (state != ESPERA_PIN) || enterPin;
  assign en  = (state == ESPERA_PIN) && !enterPin;

  contador_espera #(
    .T_ESPERA (T_ESPERA)
  ) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (clr),
    .en      (en),
    .expired (expired)
  );

  always_comb begin
    nxt    = state;
    nx_int = intentos;
    nx_to  = 1'b0;
    unique case (state)
      IDLE: begin
        if (Vehiculo) begin
          nxt    = ESPERA_PIN;
          nx_int = '0;
        end
      end
      ESPERA_PIN: begin
        if (enterPin) begin
          if (pin_ok) begin
            nxt    = ABIERTO;
            nx_int = '0;
          end else if (!en_alarma) begin
            nx_int = intentos + 1'b1;
          end
        end else if (expired && !en_alarma) begin
          nxt    = IDLE;
          nx_int = '0;
          nx_to  = 1'b1;
        end
      end
      ABIERTO: begin
        if (Termino) begin
          nxt = Vehiculo ? BLOQUEO : IDLE;
        end
      end
      BLOQUEO: begin
        if (enterPin && pin_ok) begin
          nxt    = IDLE;
          nx_int = '0;
        end
      end
      default: nxt = IDLE;
    endcase
    nx_sal = flags(nxt, nx_int == MAX_I, nx_to);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      intentos <= '0;
      sal      <= flags(IDLE, 1'b0, 1'b0);
    end else begin
      state    <= nxt;
      intentos <= nx_int;
      sal      <= nx_sal;
    end
  end

  assign Cerrado  = sal.cerrado;
  assign Abierto  = sal.abierto;
  assign Alarma   = sal.alarma;
  assign Bloqueo  = sal.bloqueo;
  assign Timeout  = sal.timeout;
  assign Intentos = intentos;

endmodule

// File: tb/tb_controlador_param.sv
// Bench for controlador_param: two configurations driven by one stimulus
// stream and checked against a cycle-level reference model.
module tb_controlador_param;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Vehiculo = 1'b0;
  logic        Termino = 1'b0;
  logic        enterPin = 1'b0;
  logic [11:0] pin = '0;

  logic       cer_a, abi_a, ala_a, blo_a, to_a;
  logic [1:0] int_a;
  logic       cer_b, abi_b, ala_b, blo_b, to_b;
  logic [2:0] int_b;

  int n_chk = 0;
  int n_pass = 0;

  bit m_wait[2];
  bit m_open[2];
  bit m_lock[2];
  bit m_to[2];
  int m_wrong[2];
  int m_cnt[2];

  always #5 Clk = ~Clk;

  controlador_param dut_a (
    .Clk      (Clk),
    .Reset    (Reset),
    .Pin      (pin[7:0]),
    .enterPin (enterPin),
    .Vehiculo (Vehiculo),
    .Termino  (Termino),
    .Cerrado  (cer_a),
    .Abierto  (abi_a),
    .Alarma   (ala_a),
    .Bloqueo  (blo_a),
    .Intentos (int_a),
    .Timeout  (to_a)
  );

  controlador_param #(
    .PIN_W        (12),
    .PIN_OK       (12'hA5C),
    .MAX_INTENTOS (5),
    .T_ESPERA     (16)
  ) dut_b (
    .Clk      (Clk),
    .Reset    (Reset),
    .Pin      (pin),
    .enterPin (enterPin),
    .Vehiculo (Vehiculo),
    .Termino  (Termino),
    .Cerrado  (cer_b),
    .Abierto  (abi_b),
    .Alarma   (ala_b),
    .Bloqueo  (blo_b),
    .Intentos (int_b),
    .Timeout  (to_b)
  );

  function automatic logic [7:0] v(
    input logic c, input logic a, input logic al,
    input logic b, input logic t, input logic [2:0] i
  );
    return {c, a, al, b, t, i};
  endfunction

  function automatic logic [7:0] got(input int s);
    if (s == 0) return v(cer_a, abi_a, ala_a, blo_a, to_a, {1'b0, int_a});
    return v(cer_b, abi_b, ala_b, blo_b, to_b, int_b);
  endfunction

  function automatic int maxi(input int s);
    return (s == 0) ? 3 : 5;
  endfunction

  function automatic logic [7:0] expv(input int s);
    logic al;
    al = m_lock[s] || (m_wait[s] && (m_wrong[s] == maxi(s)));
    return v(!m_open[s], m_open[s], al, m_lock[s], m_to[s], 3'(m_wrong[s]));
  endfunction

  // Reference behaviour, written as plain rules over flags and counts.
  task automatic model(input int s, input bit rst, input bit veh,
                       input bit ter, input bit ent, input logic [11:0] p);
    bit ok;
    ok = (s == 0) ? (p[7:0] == 8'h35) : (p == 12'hA5C);
    m_to[s] = 1'b0;
    if (rst) begin
      m_wait[s] = 0; m_open[s] = 0; m_lock[s] = 0;
      m_wrong[s] = 0; m_cnt[s] = 0;
    end else if (m_wait[s]) begin
      if (ent) begin
        m_cnt[s] = 0;
        if (ok) begin
          m_wait[s] = 0; m_open[s] = 1; m_wrong[s] = 0;
        end else if (m_wrong[s] < maxi(s)) begin
          m_wrong[s]++;
        end
      end else begin
        m_cnt[s]++;
        if (m_cnt[s] >= 16 && m_wrong[s] < maxi(s)) begin
          m_wait[s] = 0; m_to[s] = 1; m_wrong[s] = 0;
        end
      end
    end else if (m_open[s]) begin
      if (ter) begin
        m_open[s] = 0;
        m_lock[s] = veh;
      end
    end else if (m_lock[s]) begin
      if (ent && ok) begin
        m_lock[s] = 0; m_wrong[s] = 0;
      end
    end else if (veh) begin
      m_wait[s] = 1; m_wrong[s] = 0; m_cnt[s] = 0;
    end
  endtask

  task automatic step(input bit rst, input bit veh, input bit ter,
                      input bit ent, input logic [11:0] p);
    Reset = rst; Vehiculo = veh; Termino = ter; enterPin = ent; pin = p;
    @(posedge Clk);
    model(0, rst, veh, ter, ent, p);
    model(1, rst, veh, ter, ent, p);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1, 12'hA5C);
    for (int s = 0; s < 2; s++) begin
      n_chk++;
      if (got(s) !== v(1, 0, 0, 0, 0, 0))
        $display("FAIL reset dut%0d got=%b want=%b", s, got(s), v(1, 0, 0, 0, 0, 0));
      else n_pass++;
    end
  endtask

  task automatic test_pin_ok();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    n_chk++;
    if (got(0) !== v(1, 0, 0, 0, 0, 0))
      $display("FAIL wait_entry got=%b want=%b", got(0), v(1, 0, 0, 0, 0, 0));
    else n_pass++;
    step(0, 1, 0, 1, 12'h035);
    n_chk++;
    if (got(0) !== v(0, 1, 0, 0, 0, 0))
      $display("FAIL open got=%b want=%b", got(0), v(0, 1, 0, 0, 0, 0));
    else n_pass++;
    step(0, 0, 1, 0, 0);
    n_chk++;
    if (got(0) !== v(1, 0, 0, 0, 0, 0))
      $display("FAIL close got=%b want=%b", got(0), v(1, 0, 0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_wrong_pins();
    logic [7:0] w;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1, 12'h000);
      w = v(1, 0, i == 3, 0, 0, 3'(i));
      n_chk++;
      if (got(0) !== w) $display("FAIL wrong_a%0d got=%b want=%b", i, got(0), w);
      else n_pass++;
    end
    step(0, 0, 0, 1, 12'h035);
    n_chk++;
    if (got(0) !== v(0, 1, 0, 0, 0, 0))
      $display("FAIL recover_a got=%b want=%b", got(0), v(0, 1, 0, 0, 0, 0));
    else n_pass++;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0, 1, 12'h035);
      w = v(1, 0, i >= 5, 0, 0, 3'((i > 5) ? 5 : i));
      n_chk++;
      if (got(1) !== w) $display("FAIL wrong_b%0d got=%b want=%b", i, got(1), w);
      else n_pass++;
    end
    step(0, 0, 0, 1, 12'hA5C);
    n_chk++;
    if (got(1) !== v(0, 1, 0, 0, 0, 0))
      $display("FAIL recover_b got=%b want=%b", got(1), v(0, 1, 0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_timeout();
    int pulses;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) step(0, 0, 0, 0, 0);
    n_chk++;
    if (to_a !== 1'b0) $display("FAIL early_timeout got=%b want=0", to_a);
    else n_pass++;
    step(0, 0, 0, 0, 0);
    n_chk++;
    if (got(0) !== v(1, 0, 0, 0, 1, 0))
      $display("FAIL timeout got=%b want=%b", got(0), v(1, 0, 0, 0, 1, 0));
    else n_pass++;
    step(0, 0, 0, 0, 0);
    n_chk++;
    if (got(0) !== v(1, 0, 0, 0, 0, 0))
      $display("FAIL timeout_pulse got=%b want=%b", got(0), v(1, 0, 0, 0, 0, 0));
    else n_pass++;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 12'h000);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0, 0, 0);
      if (to_a) pulses++;
    end
    n_chk++;
    if (pulses != 0 || got(0) !== v(1, 0, 1, 0, 0, 3))
      $display("FAIL alarm_no_timeout got=%b pulses=%0d want=%b pulses=0",
               got(0), pulses, v(1, 0, 1, 0, 0, 3));
    else n_pass++;
  endtask

  task automatic test_enter_at_expiry();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 12'h0FF);
    n_chk++;
    if (got(0) !== v(1, 0, 0, 0, 0, 1))
      $display("FAIL enter_at_expiry got=%b want=%b", got(0), v(1, 0, 0, 0, 0, 1));
    else n_pass++;
  endtask

  task automatic test_tailgate();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 12'h035);
    n_chk++;
    if (got(0) !== v(1, 0, 0, 0, 0, 0))
      $display("FAIL idle_enter got=%b want=%b", got(0), v(1, 0, 0, 0, 0, 0));
    else n_pass++;
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 12'h035);
    step(0, 1, 1, 0, 0);
    n_chk++;
    if (got(0) !== v(1, 0, 1, 1, 0, 0))
      $display("FAIL lock got=%b want=%b", got(0), v(1, 0, 1, 1, 0, 0));
    else n_pass++;
    step(0, 0, 0, 1, 12'h011);
    n_chk++;
    if (got(0) !== v(1, 0, 1, 1, 0, 0))
      $display("FAIL lock_wrong got=%b want=%b", got(0), v(1, 0, 1, 1, 0, 0));
    else n_pass++;
    step(0, 0, 0, 1, 12'h035);
    n_chk++;
    if (got(0) !== v(1, 0, 0, 0, 0, 0))
      $display("FAIL unlock got=%b want=%b", got(0), v(1, 0, 0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 12'h000);
    step(0, 0, 0, 1, 12'h000);
    step(1, 1, 0, 1, 12'h035);
    n_chk++;
    if (got(0) !== v(1, 0, 0, 0, 0, 0))
      $display("FAIL reset_mid got=%b want=%b", got(0), v(1, 0, 0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] p;
    bit rst, veh, ter, ent;
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      veh = ($urandom_range(0, 9) < 3);
      ter = ($urandom_range(0, 9) < 3);
      ent = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 3))
        0: p = 12'hA5C;
        1: p = 12'h035;
        2: p = 12'hA35;
        default: p = 12'($urandom);
      endcase
      step(rst, veh, ter, ent, p);
      for (int s = 0; s < 2; s++) begin
        n_chk++;
        if (got(s) !== expv(s))
          $display("FAIL random dut%0d cyc=%0d got=%b want=%b", s, c, got(s), expv(s));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pin_ok();
    test_wrong_pins();
    test_timeout();
    test_enter_at_expiry();
    test_tailgate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
